// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline stages (IF, ID, EXE).
// Word width, the NOP encoding, the sequential PC step, the IF/ID payload
// layout and the built-in instruction image used by the fetch ROM.
package arm_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // All-zero word is treated as a bubble by decode.
  localparam word_t NOP_INSTR = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam word_t PC_STEP = 32'd4;

  // Payload carried from fetch to decode.
  typedef struct packed {
    word_t pc;     // PC+4 of the instruction held
    word_t instr;  // fetched instruction word
    logic  valid;  // 1 = real instruction, 0 = bubble
  } if_id_t;

  // Built-in program image. Every word is distinct per index, so a wrong
  // fetch address always shows up as a wrong instruction downstream.
  function automatic word_t imem_image_word(input int unsigned idx);
    logic [7:0] lo_byte;
    lo_byte = 8'(idx * 3);
    return {8'hE2, idx[7:0], 8'h80, lo_byte};
  endfunction

endpackage

// File: rtl/if_stage_imem.sv
// Combinational, word-addressed instruction ROM.
// The ROM holds the built-in program image from arm_pkg. An empty
// IMEM_FILE name selects an all-NOP image instead.
module instruction_memory import arm_pkg::*; #(
  parameter int    IMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "instructions.mem"
) (
  input  logic [$clog2(IMEM_DEPTH)-1:0] addr_i,
  output word_t                         data_o
);

  localparam bit IMAGE_EN = (IMEM_FILE != "");

  word_t rom [IMEM_DEPTH];

  // Constant ROM contents; synthesis folds this into a lookup table.
  always_comb begin
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      rom[i] = IMAGE_EN ? imem_image_word(i) : NOP_INSTR;
    end
  end

  // The index spans the whole ROM, so every address is in range.
  assign data_o = rom[addr_i];

endmodule

// File: rtl/if_stage_reg.sv
// Generic enabled register with asynchronous active-high reset.
// Used for both the PC and the IF/ID pipeline register so the two share
// identical reset and hold behaviour.
module pipe_register #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // Load on enable, otherwise hold; reset wins immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= RST_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Holds the PC, reads the instruction ROM combinationally and registers
// {PC+4, instruction, valid} for decode.
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt and
// bubble_cnt performance counters.
//
// Flow control: there is no valid/ready pair here. IF_valid qualifies
// PC_out and Instruction. freeze is the only back-pressure: with freeze
// high and both Branch_taken and flush low, no state changes. A taken
// branch redirects the PC even when frozen, and flush clears IF/ID even
// when frozen.
module if_stage import arm_pkg::*; #(
  parameter int          IMEM_DEPTH = 64,
  parameter string       IMEM_FILE  = "instructions.mem",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] BranchAddr,
  input  logic        flush,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction,
  output logic        IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Program counter
  word_t pc_q;
  word_t pc_d;
  word_t pc_plus4;
  logic  pc_en;

  // IF/ID register
  if_id_t ifid_q;
  if_id_t ifid_d;
  logic   ifid_en;

  // ROM interface
  logic [AW-1:0] imem_addr;
  word_t         imem_word;

  // Branch targets are forced to word alignment; the low bits are dropped.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^BranchAddr[1:0];

  // Sequential step wraps naturally at 2^32.
  assign pc_plus4 = pc_q + PC_STEP;

  // Upper PC bits are ignored: fetch addresses alias modulo the ROM size.
  assign imem_addr = pc_q[AW+1:2];

  instruction_memory #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_FILE  (IMEM_FILE)
  ) u_imem (
    .addr_i (imem_addr),
    .data_o (imem_word)
  );

  // PC next state: a taken branch beats freeze, otherwise step by 4.
  always_comb begin
    pc_d  = pc_plus4;
    pc_en = 1'b1;
    if (Branch_taken) begin
      pc_d = {BranchAddr[31:2], 2'b00};
    end else if (freeze) begin
      pc_en = 1'b0;
    end
  end

  pipe_register #(
    .W       (WORD_W),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (pc_en),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // IF/ID next state: flush beats freeze, otherwise capture the fetch.
  always_comb begin
    ifid_d.pc    = pc_plus4;
    ifid_d.instr = imem_word;
    ifid_d.valid = 1'b1;
    ifid_en      = 1'b1;
    if (flush) begin
      ifid_d.pc    = '0;
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
    end else if (freeze) begin
      ifid_en = 1'b0;
    end
  end

  pipe_register #(
    .W       ($bits(if_id_t)),
    .RST_VAL ('0)
  ) u_ifid_reg (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (ifid_en),
    .d_i   (ifid_d),
    .q_o   (ifid_q)
  );

  assign PC_out      = ifid_q.pc;
  assign Instruction = ifid_q.instr;
  assign IF_valid    = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  word_t fetch_cnt_q;
  word_t bubble_cnt_q;

  // Every non-reset edge is either a real load or a blocked one, counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (flush || freeze) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
